// File: rtl/pipe_adder.sv
// Pipelined ripple-carry adder/subtractor. Each stage adds one CHUNK-bit
// slice and registers the carry for the next slice. The last stage register
// drives the result. All stages share one stall signal, so a held output
// freezes the entire pipe.

module pipe_adder_slice #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             c_i,
    output logic [CHUNK-1:0] s_o,
    output logic             c_o
);
    assign {c_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, c_i};
endmodule

module pipe_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int STAGES = WIDTH / CHUNK;

    logic                          advance;
    logic [WIDTH-1:0]              b_eff;
    logic                          c0;

    // per-stage registers
    logic [STAGES-1:0]             vld_q;
    logic [STAGES-1:0]             cy_q;
    logic [STAGES-1:0][WIDTH-1:0]  a_q;
    logic [STAGES-1:0][WIDTH-1:0]  b_q;
    logic [STAGES-1:0][WIDTH-1:0]  res_q;

    // what each stage sees on its input side, and what it will register
    logic [STAGES-1:0]             src_v;
    logic [STAGES-1:0]             src_c;
    logic [STAGES-1:0][WIDTH-1:0]  src_a;
    logic [STAGES-1:0][WIDTH-1:0]  src_b;
    logic [STAGES-1:0][WIDTH-1:0]  src_r;
    logic [STAGES-1:0][CHUNK-1:0]  sl_s;
    logic [STAGES-1:0]             sl_c;
    logic [STAGES-1:0][WIDTH-1:0]  res_d;

    // The pipe moves whenever the output slot is empty or being drained.
    assign advance  = !vld_q[STAGES-1] || out_ready;
    assign in_ready = advance;

    // Subtraction is a + ~b + 1. The carry-in is forced to 1, so cin is ignored.
    assign b_eff = sub ? ~b : b;
    assign c0    = sub | cin;

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        if (k == 0) begin : g_head
            assign src_v[k] = in_valid;
            assign src_c[k] = c0;
            assign src_a[k] = a;
            assign src_b[k] = b_eff;
            assign src_r[k] = '0;
        end else begin : g_body
            assign src_v[k] = vld_q[k-1];
            assign src_c[k] = cy_q[k-1];
            assign src_a[k] = a_q[k-1];
            assign src_b[k] = b_q[k-1];
            assign src_r[k] = res_q[k-1];
        end

        pipe_adder_slice #(.CHUNK(CHUNK)) u_slice (
            .a_i (src_a[k][k*CHUNK +: CHUNK]),
            .b_i (src_b[k][k*CHUNK +: CHUNK]),
            .c_i (src_c[k]),
            .s_o (sl_s[k]),
            .c_o (sl_c[k])
        );

        // Lower slices pass through unchanged. This stage's slice is spliced in.
        always_comb begin
            res_d[k]                      = src_r[k];
            res_d[k][k*CHUNK +: CHUNK]    = sl_s[k];
        end
    end

    // Shift valid bits every advance. Data loads only behind a real op, so a
    // bubble leaves the previous result on the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            cy_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            res_q <= '0;
        end else if (advance) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_q[k] <= src_v[k];
                if (src_v[k]) begin
                    cy_q[k]  <= sl_c[k];
                    a_q[k]   <= src_a[k];
                    b_q[k]   <= src_b[k];
                    res_q[k] <= res_d[k];
                end
            end
        end
    end

    assign out_valid = vld_q[STAGES-1];
    assign sum       = res_q[STAGES-1];
    assign cout      = cy_q[STAGES-1];
    // The full operands ride along, so the MSBs are available for signed overflow.
    assign ovf       = (a_q[STAGES-1][WIDTH-1] == b_q[STAGES-1][WIDTH-1]) &&
                       (res_q[STAGES-1][WIDTH-1] != a_q[STAGES-1][WIDTH-1]);

endmodule

// File: tb/tb_pipe_adder.sv
// Bench for pipe_adder. A 32/8 instance gets directed, streaming,
// backpressure and reset traffic. A 16/16 instance covers the single-stage
// case. The expected results come from plain integer arithmetic.

module tb_pipe_adder;
    localparam int W  = 32;
    localparam int C  = 8;
    localparam int ST = W / C;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic        iv, ir, ov, ordy, ci, sb, co, of;
    logic [31:0] a, b, s;
    logic        iv1, ir1, ov1, ordy1, ci1, sb1, co1, of1;
    logic [15:0] a1, b1, s1;

    pipe_adder #(.WIDTH(W), .CHUNK(C)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir), .a(a), .b(b),
        .cin(ci), .sub(sb), .out_valid(ov), .out_ready(ordy), .sum(s),
        .cout(co), .ovf(of)
    );

    pipe_adder #(.WIDTH(16), .CHUNK(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
        .cin(ci1), .sub(sb1), .out_valid(ov1), .out_ready(ordy1), .sum(s1),
        .cout(co1), .ovf(of1)
    );

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    bit lat_on = 0;

    typedef struct { logic [33:0] exp; int acc; } exp_t;
    exp_t q[$];
    exp_t e;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // The result is packed as {ovf, cout, sum[31:0]}.
    function automatic logic [33:0] model(int w, logic [31:0] ta, logic [31:0] tb_,
                                          logic tc, logic ts);
        longint m, half, ua, ub, sa, sb_, us, ss;
        logic   c, o;
        m    = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        ua   = longint'(ta) & m;
        ub   = longint'(tb_) & m;
        sa   = (ua >= half) ? ua - (m + 1) : ua;
        sb_  = (ub >= half) ? ub - (m + 1) : ub;
        if (ts) begin
            us = ua - ub;
            ss = sa - sb_;
            c  = (ua >= ub);
        end else begin
            us = ua + ub + longint'(tc);
            ss = sa + sb_ + longint'(tc);
            c  = (us > m);
        end
        o  = (ss > half - 1) || (ss < -half);
        us = us & m;
        return {o, c, us[31:0]};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard and handshake monitor for the 32-bit instance
    logic        pv = 1'b0;
    logic        pr = 1'b1;
    logic [33:0] pout = '0;
    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready", ir, !ov || ordy);
            if (pv && !pr) chk("stall_hold", {ov, of, co, s}, {1'b1, pout});
            if (ov && ordy) begin
                if (q.size() == 0) chk("extra_out", ov, 0);
                else begin
                    e = q.pop_front();
                    chk("result", {of, co, s}, e.exp);
                    if (lat_on) chk("latency", cyc - e.acc, ST - 1);
                end
            end
            pv = ov; pr = ordy; pout = {of, co, s};
        end else begin
            pv = 1'b0;
        end
    end

    task automatic send(logic [31:0] ta, logic [31:0] tb_, logic tc, logic ts, logic [33:0] exp);
        bit done = 0;
        int t = 0;
        iv = 1'b1; a = ta; b = tb_; ci = tc; sb = ts;
        while (!done && t < 60) begin
            @(negedge clk);
            if (ir) begin
                q.push_back('{exp, cyc + 1});
                done = 1;
            end
            @(posedge clk); #1;
            t++;
        end
        if (!done) chk("send_timeout", ir, 1);
    endtask

    task automatic rnd_send();
        logic [31:0] ta, tb_;
        logic tc, ts;
        ta = $urandom; tb_ = $urandom; tc = 1'($urandom); ts = 1'($urandom);
        send(ta, tb_, tc, ts, model(32, ta, tb_, tc, ts));
    endtask

    task automatic idle(int n);
        iv = 1'b0; a = $urandom; b = $urandom; ci = 1'($urandom); sb = 1'($urandom);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int t = 0;
        while (q.size() > 0 && t < 200) begin
            @(posedge clk);
            t++;
        end
        #1;
        chk("drain", q.size(), 0);
    endtask

    task automatic send16(logic [15:0] ta, logic [15:0] tb_, logic tc, logic ts, logic [33:0] exp);
        iv1 = 1'b1; a1 = ta; b1 = tb_; ci1 = tc; sb1 = ts;
        @(negedge clk);
        chk("in_ready16", ir1, 1);
        @(posedge clk); #1;
        iv1 = 1'b0; a1 = 16'($urandom); b1 = 16'($urandom);
        @(negedge clk);
        chk("res16", {ov1, of1, co1, s1}, {1'b1, exp[33], exp[32], exp[15:0]});
        @(posedge clk);
        @(negedge clk);
        chk("bubble16", ov1, 0);
        @(posedge clk); #1;
    endtask

    // directed cases: a, b, cin, sub, then the expected {ovf, cout, sum}
    logic [31:0] da[6] = '{32'h0000_00FF, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'd5, 32'd7, 32'h8000_0000};
    logic [31:0] db[6] = '{32'h1, 32'h0, 32'h1, 32'd7, 32'd5, 32'h1};
    logic        dc[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic        ds[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [33:0] de[6] = '{{2'b00, 32'h0000_0100}, {2'b01, 32'h0000_0000}, {2'b10, 32'h8000_0000},
                           {2'b00, 32'hFFFF_FFFE}, {2'b01, 32'h0000_0002}, {2'b11, 32'h7FFF_FFFF}};
    logic [15:0] ea[3] = '{16'h00FF, 16'hFFFF, 16'h7FFF};
    logic [15:0] eb[3] = '{16'h1, 16'h0, 16'h1};
    logic        ec[3] = '{1'b0, 1'b1, 1'b0};
    logic [33:0] ee[3] = '{{2'b00, 32'h0100}, {2'b01, 32'h0000}, {2'b10, 32'h8000}};

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, expected finish earlier");
        $fatal(1);
    end

    initial begin
        int nout;
        iv = 0; ordy = 1; a = 0; b = 0; ci = 0; sb = 0;
        iv1 = 0; ordy1 = 1; a1 = 0; b1 = 0; ci1 = 0; sb1 = 0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", ov, 0);
        chk("rst_sum", s, 0);
        chk("rst_cout", co, 0);
        chk("rst_ovf", of, 0);
        chk("rst_out_valid16", ov1, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_in_ready", ir, 1);

        // directed, isolated, with the latency checked
        lat_on = 1;
        for (int i = 0; i < 6; i++) begin
            send(da[i], db[i], dc[i], ds[i], de[i]);
            idle(6);
        end

        // back-to-back stream, one result per cycle at fixed latency
        for (int i = 0; i < 20; i++) rnd_send();
        idle(1);
        drain();
        lat_on = 0;

        // random backpressure with one long hold
        fork
            begin
                for (int i = 0; i < 10; i++) rnd_send();
                idle(1);
            end
            begin
                for (int i = 0; i < 40; i++) begin
                    ordy = (i >= 8 && i < 14) ? 1'b0 : 1'($urandom);
                    @(posedge clk); #1;
                end
                ordy = 1'b1;
            end
        join
        drain();

        // reset while stalled with three ops in flight
        ordy = 1'b0;
        for (int i = 0; i < 3; i++) rnd_send();
        idle(5);
        chk("stall_valid", ov, 1);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", ov, 0);
        chk("mid_rst_sum", s, 0);
        chk("mid_rst_cout", co, 0);
        chk("mid_rst_ovf", of, 0);
        q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1; ordy = 1'b1;
        nout = 0;
        repeat (10) begin
            @(negedge clk);
            if (ov) nout++;
        end
        @(posedge clk); #1;
        chk("stale_out", nout, 0);

        // single-stage instance
        for (int i = 0; i < 3; i++) send16(ea[i], eb[i], ec[i], 1'b0, ee[i]);
        for (int i = 0; i < 6; i++) begin
            logic [15:0] ta, tb_;
            logic tc, ts;
            ta = 16'($urandom); tb_ = 16'($urandom); tc = 1'($urandom); ts = 1'($urandom);
            send16(ta, tb_, tc, ts, model(16, {16'h0, ta}, {16'h0, tb_}, tc, ts));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
